// File: rtl/text_pkg.sv
// Shared text-mode definitions: opcodes, executor state encoding and default geometry.
// Also imported by the CPU register file so both sides agree on opcode values.
package text_pkg;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 30;

    localparam logic [7:0] TEXT_WRITE    = 8'h00;
    localparam logic [7:0] TEXT_POSITION = 8'h01;
    localparam logic [7:0] TEXT_CLEAR    = 8'h02;
    localparam logic [7:0] GET_TEXT_AT   = 8'h03;

    localparam logic [7:0] SPACE_CHAR = 8'h20;

    typedef enum logic [2:0] {
        IDLE, EXEC, FILL, RD_WAIT, SCROLL_RD, SCROLL_WR, SCROLL_CLR, DONE
    } state_t;

    // Pixel opcodes (0x10 and up) belong to the graphics executor.
    function automatic logic is_text_op(input logic [7:0] op);
        return op <= GET_TEXT_AT;
    endfunction

endpackage

// File: rtl/text_cursor.sv
// Text cursor: col/row counters with load, advance and a bounds check on candidate coordinates.
// With TEXT_SCROLL_EN defined it also exports a flag marking the last cell of the screen.
module text_cursor
    import text_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS,
    parameter int ROWS = DEFAULT_ROWS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_col,
    input  logic [7:0] load_row,
    input  logic       advance,
    input  logic [7:0] check_col,
    input  logic [7:0] check_row,
`ifdef TEXT_SCROLL_EN
    output logic       at_last_cell,
`endif
    output logic       check_ok,
    output logic [7:0] col,
    output logic [7:0] row
);
    localparam logic [7:0] LAST_COL = 8'(COLS - 1);
    localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

`ifdef TEXT_SCROLL_EN
    assign at_last_cell = (col == LAST_COL) && (row == LAST_ROW);
`endif
    assign check_ok = (check_col <= LAST_COL) && (check_row <= LAST_ROW);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (load) begin
            col <= load_col;
            row <= load_row;
        end else if (advance) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + 8'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

endmodule

// File: rtl/text_instruction_executor.sv
// Executes text opcodes 0x00-0x03 against character VRAM over a req/ack port.
// Define TEXT_SCROLL_EN to scroll the screen up on a cursor wrap past the last row.
module text_instruction_executor
    import text_pkg::*;
#(
    parameter int COLS   = DEFAULT_COLS,
    parameter int ROWS   = DEFAULT_ROWS,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        instruction,
    input  logic [7:0]        arg0,
    input  logic [7:0]        arg1,
    input  logic              instruction_start,
    output logic              instruction_busy,
    output logic              instruction_finished,
    output logic              instruction_error,
    output logic [7:0]        result_0,
    output logic [7:0]        result_1,
    output logic              vram_req,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [15:0]       vram_wdata,
    input  logic              vram_ack,
    input  logic [15:0]       vram_rdata
);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
`ifdef TEXT_SCROLL_EN
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [7:0]        LAST_ROW      = 8'(ROWS - 1);
    logic at_last_cell;
`endif

    state_t      state;
    logic [7:0]  op, arg0_q, arg1_q;
    logic [7:0]  cur_col, cur_row, load_col, load_row;
    logic        cur_load, cur_advance, arg_ok;
    logic        acked;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] c, input logic [7:0] r);
        return ADDR_W'(r) * COLS_A + ADDR_W'(c);
    endfunction

    assign acked = vram_req && vram_ack;

    text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk       (clk),
        .reset     (reset),
        .load      (cur_load),
        .load_col  (load_col),
        .load_row  (load_row),
        .advance   (cur_advance),
        .check_col (arg0_q),
        .check_row (arg1_q),
`ifdef TEXT_SCROLL_EN
        .at_last_cell (at_last_cell),
`endif
        .check_ok  (arg_ok),
        .col       (cur_col),
        .row       (cur_row)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cur_load    = 1'b0;
        load_col    = 8'd0;
        load_row    = 8'd0;
        cur_advance = (state == FILL) && (op == TEXT_WRITE) && acked;
        if (state == EXEC && op == TEXT_POSITION && arg_ok) begin
            cur_load = 1'b1;
            load_col = arg0_q;
            load_row = arg1_q;
        end else if (state == FILL && op == TEXT_CLEAR && acked && vram_addr == LAST_CELL) begin
            cur_load = 1'b1;
        end
`ifdef TEXT_SCROLL_EN
        else if (state == SCROLL_CLR && acked && vram_addr == LAST_CELL) begin
            cur_load = 1'b1;
            load_row = LAST_ROW;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            op                   <= '0;
            arg0_q               <= '0;
            arg1_q               <= '0;
            instruction_busy     <= 1'b0;
            instruction_finished <= 1'b0;
            instruction_error    <= 1'b0;
            result_0             <= '0;
            result_1             <= '0;
            vram_req             <= 1'b0;
            vram_we              <= 1'b0;
            vram_addr            <= '0;
            vram_wdata           <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    instruction_finished <= 1'b0;
                    state                <= IDLE;
                    if (instruction_start && is_text_op(instruction)) begin
                        op                <= instruction;
                        arg0_q            <= arg0;
                        arg1_q            <= arg1;
                        instruction_error <= 1'b0;
                        instruction_busy  <= 1'b1;
                        state             <= EXEC;
                    end
                end
                EXEC: begin
                    case (op)
                        TEXT_WRITE: begin
                            vram_req   <= 1'b1;
                            vram_we    <= 1'b1;
                            vram_addr  <= cell_addr(cur_col, cur_row);
                            vram_wdata <= {arg0_q, arg1_q};
                            state      <= FILL;
                        end
                        TEXT_POSITION: begin
                            instruction_error    <= !arg_ok;
                            instruction_busy     <= 1'b0;
                            instruction_finished <= 1'b1;
                            state                <= DONE;
                        end
                        TEXT_CLEAR: begin
                            vram_req   <= 1'b1;
                            vram_we    <= 1'b1;
                            vram_addr  <= '0;
                            vram_wdata <= {arg0_q, SPACE_CHAR};
                            state      <= FILL;
                        end
                        default: begin
                            if (arg_ok) begin
                                vram_req  <= 1'b1;
                                vram_we   <= 1'b0;
                                vram_addr <= cell_addr(arg0_q, arg1_q);
                                state     <= RD_WAIT;
                            end else begin
                                instruction_error    <= 1'b1;
                                instruction_busy     <= 1'b0;
                                instruction_finished <= 1'b1;
                                state                <= DONE;
                            end
                        end
                    endcase
                end
                // Single-cell writes and clear sweeps share this state; op tells them apart.
                FILL: begin
                    if (acked) begin
                        if (op == TEXT_WRITE) begin
                            vram_req <= 1'b0;
`ifdef TEXT_SCROLL_EN
                            if (at_last_cell) begin
                                vram_req  <= 1'b1;
                                vram_we   <= 1'b0;
                                vram_addr <= COLS_A;
                                state     <= SCROLL_RD;
                            end else begin
                                instruction_busy     <= 1'b0;
                                instruction_finished <= 1'b1;
                                state                <= DONE;
                            end
`else
                            instruction_busy     <= 1'b0;
                            instruction_finished <= 1'b1;
                            state                <= DONE;
`endif
                        end else if (vram_addr == LAST_CELL) begin
                            vram_req             <= 1'b0;
                            instruction_busy     <= 1'b0;
                            instruction_finished <= 1'b1;
                            state                <= DONE;
                        end else begin
                            vram_addr <= vram_addr + ADDR_W'(1);
                        end
                    end
                end
                RD_WAIT: begin
                    if (acked) begin
                        vram_req             <= 1'b0;
                        result_0             <= vram_rdata[7:0];
                        result_1             <= vram_rdata[15:8];
                        instruction_busy     <= 1'b0;
                        instruction_finished <= 1'b1;
                        state                <= DONE;
                    end
                end
`ifdef TEXT_SCROLL_EN
                // Copy each cell one row up: read cell+COLS, then write it back at cell.
                SCROLL_RD: begin
                    if (acked) begin
                        vram_we    <= 1'b1;
                        vram_addr  <= vram_addr - COLS_A;
                        vram_wdata <= vram_rdata;
                        state      <= SCROLL_WR;
                    end
                end
                SCROLL_WR: begin
                    if (acked) begin
                        if (vram_addr == LAST_ROW_BASE - ADDR_W'(1)) begin
                            vram_addr  <= LAST_ROW_BASE;
                            vram_wdata <= {arg0_q, SPACE_CHAR};
                            state      <= SCROLL_CLR;
                        end else begin
                            vram_we   <= 1'b0;
                            vram_addr <= vram_addr + ADDR_W'(1) + COLS_A;
                            state     <= SCROLL_RD;
                        end
                    end
                end
                SCROLL_CLR: begin
                    if (acked) begin
                        if (vram_addr == LAST_CELL) begin
                            vram_req             <= 1'b0;
                            instruction_busy     <= 1'b0;
                            instruction_finished <= 1'b1;
                            state                <= DONE;
                        end else begin
                            vram_addr <= vram_addr + ADDR_W'(1);
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
